// File: rtl/fetch_pkg.sv
// Shared widths, packet type and address helpers for the instruction fetch unit.
package fetch_pkg;

    localparam int FETCH_BUS = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [FETCH_BUS-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [FETCH_BUS-1:0] instr;
        logic [FETCH_BUS-1:0] pc;
    } fetch_pkt_t;

    // Which of the four mutually exclusive things the front end does this cycle.
    typedef enum logic [1:0] {
        FETCH_RESET,
        FETCH_BRANCH,
        FETCH_ADVANCE,
        FETCH_STALL
    } fetch_mode_e;

    function automatic logic [FETCH_BUS-1:0] word_align(input logic [FETCH_BUS-1:0] addr);
        return addr & ~FETCH_BUS'(INSTR_BYTES - 1);
    endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// Next fetch-PC and instruction-memory address selection for fetch_unit.
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int               bus      = FETCH_BUS,
    parameter logic [bus-1:0]   reset_pc = DEFAULT_RESET_PC
) (
    input  logic            reset,
    input  logic            advance,
    input  logic            branch_valid,
    input  logic [bus-1:0]  branch_target,
    input  logic [bus-1:0]  pc_f,
    input  logic [bus-1:0]  pend_pc,
    output fetch_mode_e     mode,
    output logic [bus-1:0]  pc_f_next,
    output logic [bus-1:0]  imem_addr
);

    localparam logic [bus-1:0] STEP     = bus'(INSTR_BYTES);
    localparam logic [bus-1:0] RESET_PC = word_align(reset_pc);

    logic [bus-1:0] target_aligned;

    // Reset beats branch, branch beats stall; a stall re-reads the pending word.
    always_comb begin
        mode           = FETCH_STALL;
        pc_f_next      = pc_f;
        imem_addr      = pend_pc;
        target_aligned = word_align(branch_target);

        if (reset) begin
            mode = FETCH_RESET;
        end else if (branch_valid) begin
            mode = FETCH_BRANCH;
        end else if (advance) begin
            mode = FETCH_ADVANCE;
        end

        case (mode)
            FETCH_RESET: begin
                imem_addr = RESET_PC;
                pc_f_next = RESET_PC;
            end
            FETCH_BRANCH: begin
                imem_addr = target_aligned;
                pc_f_next = target_aligned + STEP;
            end
            FETCH_ADVANCE: begin
                imem_addr = pc_f;
                pc_f_next = pc_f + STEP;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Two-stage instruction fetch front end with a one-deep in-flight slot and decode output register.
// Optional FETCH_PERF_EN adds fetched/squashed performance counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int               bus      = FETCH_BUS,
    parameter logic [bus-1:0]   reset_pc = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            reset,
    output logic [bus-1:0]  imem_addr,
    input  logic [bus-1:0]  imem_data,
    input  logic            branch_valid,
    input  logic [bus-1:0]  branch_target,
    input  logic            dec_ready,
    output logic            dec_valid,
    output logic [bus-1:0]  dec_instr,
    output logic [bus-1:0]  dec_pc,
    output logic [bus-1:0]  dec_pc_plus8
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_squashed
`endif
);

    localparam logic [bus-1:0] RESET_PC = word_align(reset_pc);

    fetch_mode_e    mode;
    logic           advance;
    logic [bus-1:0] pc_f_q, pc_f_d;
    logic           pend_valid_q, pend_valid_d;
    fetch_pkt_t     pend_q, pend_d;
    logic           out_valid_q, out_valid_d;
    fetch_pkt_t     out_q, out_d;

    assign advance = !out_valid_q || dec_ready;

    fetch_pc_gen #(
        .bus      (bus),
        .reset_pc (reset_pc)
    ) u_pc_gen (
        .reset         (reset),
        .advance       (advance),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .pc_f          (pc_f_q),
        .pend_pc       (pend_q.pc),
        .mode          (mode),
        .pc_f_next     (pc_f_d),
        .imem_addr     (imem_addr)
    );

    // The in-flight slot only tracks the address; its word arrives on imem_data next cycle.
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_d       = pend_q;
        out_valid_d  = out_valid_q;
        out_d        = out_q;

        case (mode)
            FETCH_BRANCH: begin
                out_valid_d  = 1'b0;
                pend_valid_d = 1'b1;
                pend_d.pc    = imem_addr;
                pend_d.instr = '0;
            end
            FETCH_ADVANCE: begin
                out_valid_d  = pend_valid_q;
                out_d.instr  = imem_data;
                out_d.pc     = pend_q.pc;
                pend_valid_d = 1'b1;
                pend_d.pc    = pc_f_q;
                pend_d.instr = '0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f_q       <= RESET_PC;
            pend_valid_q <= 1'b0;
            pend_q       <= '0;
            out_valid_q  <= 1'b0;
            out_q        <= '0;
        end else begin
            pc_f_q       <= pc_f_d;
            pend_valid_q <= pend_valid_d;
            pend_q       <= pend_d;
            out_valid_q  <= out_valid_d;
            out_q        <= out_d;
        end
    end

    logic unused_pend_instr;
    assign unused_pend_instr = ^pend_q.instr;

    assign dec_valid    = out_valid_q;
    assign dec_instr    = out_q.instr;
    assign dec_pc       = out_q.pc;
    assign dec_pc_plus8 = out_q.pc + bus'(8);

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_squashed_q, perf_squashed_d;

    // A transfer can only happen in an advancing cycle; a branch discards whatever is valid.
    always_comb begin
        perf_fetched_d  = perf_fetched_q;
        perf_squashed_d = perf_squashed_q;
        if (mode == FETCH_ADVANCE && out_valid_q && dec_ready) begin
            perf_fetched_d = perf_fetched_q + 32'd1;
        end
        if (mode == FETCH_BRANCH) begin
            perf_squashed_d = perf_squashed_q + 32'(out_valid_q) + 32'(pend_valid_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched_q  <= '0;
            perf_squashed_q <= '0;
        end else begin
            perf_fetched_q  <= perf_fetched_d;
            perf_squashed_q <= perf_squashed_d;
        end
    end

    assign perf_fetched  = perf_fetched_q;
    assign perf_squashed = perf_squashed_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, PC-wrap sequence and randomized model comparison.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic        dec_ready;

    logic [31:0] imem_addr, imem_data;
    logic        dec_valid;
    logic [31:0] dec_instr, dec_pc, dec_pc_plus8;

    logic [31:0] imem_addr2, imem_data2;
    logic        dec_valid2;
    logic [31:0] dec_instr2, dec_pc2, dec_pc_plus8_2;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_squashed;
    logic [31:0] perf_fetched2, perf_squashed2;
`endif

    int n_vec;
    int n_miss;

    fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .dec_ready     (dec_ready),
        .dec_valid     (dec_valid),
        .dec_instr     (dec_instr),
        .dec_pc        (dec_pc),
        .dec_pc_plus8  (dec_pc_plus8)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_squashed (perf_squashed)
`endif
    );

    fetch_unit #(.reset_pc(32'hFFFF_FFF8)) dut_wrap (
        .clk           (clk),
        .reset         (reset),
        .imem_addr     (imem_addr2),
        .imem_data     (imem_data2),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .dec_ready     (dec_ready),
        .dec_valid     (dec_valid2),
        .dec_instr     (dec_instr2),
        .dec_pc        (dec_pc2),
        .dec_pc_plus8  (dec_pc_plus8_2)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched  (perf_fetched2),
        .perf_squashed (perf_squashed2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Contents of instruction memory as a pure function of the byte address.
    function automatic logic [31:0] memw(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[31:16] ^ a[15:0]};
    endfunction

    // Synchronous-read memory: word for the address sampled at a posedge appears one cycle later.
    always @(posedge clk) begin
        imem_data  <= memw(imem_addr);
        imem_data2 <= memw(imem_addr2);
    end

    typedef struct {
        logic        rst;
        logic        br;
        logic [31:0] tgt;
        logic        rdy;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic        chk;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        int          exp_fetched;
        int          exp_squashed;
    } vec_t;

    function automatic vec_t mkv(input logic r, input logic b, input logic [31:0] t, input logic rd,
                                 input logic [31:0] a, input logic v, input logic c,
                                 input logic [31:0] p, input logic [31:0] ins, input int f, input int s);
        vec_t x;
        x.rst = r; x.br = b; x.tgt = t; x.rdy = rd;
        x.exp_addr = a; x.exp_valid = v; x.chk = c;
        x.exp_pc = p; x.exp_instr = ins; x.exp_fetched = f; x.exp_squashed = s;
        return x;
    endfunction

    task automatic applyStimulus(input logic r, input logic b, input logic [31:0] t, input logic rd);
        reset         = r;
        branch_valid  = b;
        branch_target = t;
        dec_ready     = rd;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Transaction-level reference: queue of fetched-but-undelivered PCs plus the next fetch PC.
    logic [31:0] m_q[$];
    logic [31:0] m_next;
    logic        m_valid;
    logic [31:0] m_pc, m_instr;
    logic [31:0] m_fetched, m_squashed;

    function automatic logic [31:0] modelAddr(input logic r, input logic b, input logic [31:0] t, input logic rd);
        logic [31:0] addr;
        if (r)                    addr = 32'h0;
        else if (b)               addr = {t[31:2], 2'b00};
        else if (!m_valid || rd)  addr = m_next;
        else                      addr = (m_q.size() > 0) ? m_q[0] : m_next;
        return addr;
    endfunction

    task automatic modelStep(input logic r, input logic b, input logic [31:0] t, input logic rd);
        logic [31:0] tgt;
        tgt = {t[31:2], 2'b00};
        if (r) begin
            m_q.delete();
            m_valid = 1'b0; m_pc = '0; m_instr = '0;
            m_next = 32'h0; m_fetched = '0; m_squashed = '0;
        end else if (b) begin
            m_squashed = m_squashed + 32'(m_valid) + 32'(m_q.size());
            m_q.delete();
            m_q.push_back(tgt);
            m_valid = 1'b0;
            m_next = tgt + 32'd4;
        end else if (!m_valid || rd) begin
            if (m_valid) m_fetched = m_fetched + 32'd1;
            if (m_q.size() > 0) begin
                m_valid = 1'b1;
                m_pc    = m_q.pop_front();
                m_instr = memw(m_pc);
            end else begin
                m_valid = 1'b0;
            end
            m_q.push_back(m_next);
            m_next = m_next + 32'd4;
        end
    endtask

    vec_t        vtab[17];
    logic [31:0] wrap_pc[3];
    logic [31:0] wrap_addr[4];

    initial begin
        n_vec = 0;
        n_miss = 0;
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);

        vtab[0]  = mkv(1, 0, 32'h0,   1, 32'h0,   0, 1, 32'h0,   32'h0,        0, 0);
        vtab[1]  = mkv(1, 0, 32'h0,   1, 32'h0,   0, 1, 32'h0,   32'h0,        0, 0);
        vtab[2]  = mkv(0, 0, 32'h0,   1, 32'h0,   0, 0, 32'h0,   32'h0,        0, 0);
        vtab[3]  = mkv(0, 0, 32'h0,   1, 32'h4,   1, 1, 32'h0,   memw(32'h0),  0, 0);
        vtab[4]  = mkv(0, 0, 32'h0,   1, 32'h8,   1, 1, 32'h4,   memw(32'h4),  1, 0);
        vtab[5]  = mkv(0, 0, 32'h0,   0, 32'h8,   1, 1, 32'h4,   memw(32'h4),  1, 0);
        vtab[6]  = mkv(0, 0, 32'h0,   0, 32'h8,   1, 1, 32'h4,   memw(32'h4),  1, 0);
        vtab[7]  = mkv(0, 0, 32'h0,   0, 32'h8,   1, 1, 32'h4,   memw(32'h4),  1, 0);
        vtab[8]  = mkv(0, 0, 32'h0,   1, 32'hC,   1, 1, 32'h8,   memw(32'h8),  2, 0);
        vtab[9]  = mkv(0, 0, 32'h0,   1, 32'h10,  1, 1, 32'hC,   memw(32'hC),  3, 0);
        vtab[10] = mkv(0, 0, 32'h0,   0, 32'h10,  1, 1, 32'hC,   memw(32'hC),  3, 0);
        vtab[11] = mkv(0, 1, 32'h103, 0, 32'h100, 0, 0, 32'h0,   32'h0,        3, 2);
        vtab[12] = mkv(0, 0, 32'h0,   0, 32'h104, 1, 1, 32'h100, memw(32'h100), 3, 2);
        vtab[13] = mkv(0, 0, 32'h0,   1, 32'h108, 1, 1, 32'h104, memw(32'h104), 4, 2);
        vtab[14] = mkv(1, 1, 32'h200, 0, 32'h0,   0, 1, 32'h0,   32'h0,        0, 0);
        vtab[15] = mkv(0, 0, 32'h0,   1, 32'h0,   0, 0, 32'h0,   32'h0,        0, 0);
        vtab[16] = mkv(0, 0, 32'h0,   1, 32'h4,   1, 1, 32'h0,   memw(32'h0),  0, 0);

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            applyStimulus(vtab[i].rst, vtab[i].br, vtab[i].tgt, vtab[i].rdy);
            #1;
            checkOutput($sformatf("tbl%0d.imem_addr", i), imem_addr, vtab[i].exp_addr);
            @(posedge clk);
            #1;
            checkOutput($sformatf("tbl%0d.dec_valid", i), 32'(dec_valid), 32'(vtab[i].exp_valid));
            if (vtab[i].chk) begin
                checkOutput($sformatf("tbl%0d.dec_pc", i), dec_pc, vtab[i].exp_pc);
                checkOutput($sformatf("tbl%0d.dec_instr", i), dec_instr, vtab[i].exp_instr);
                if (vtab[i].exp_valid)
                    checkOutput($sformatf("tbl%0d.dec_pc_plus8", i), dec_pc_plus8, vtab[i].exp_pc + 32'd8);
            end
`ifdef FETCH_PERF_EN
            checkOutput($sformatf("tbl%0d.perf_fetched", i), perf_fetched, 32'(vtab[i].exp_fetched));
            checkOutput($sformatf("tbl%0d.perf_squashed", i), perf_squashed, 32'(vtab[i].exp_squashed));
`endif
        end

        // Fetch PC wrapping past the top of the address space on the high-reset-PC instance.
        wrap_pc   = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        wrap_addr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        #1;
        checkOutput("wrap.reset_addr", imem_addr2, 32'hFFFF_FFF8);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
            #1;
            checkOutput($sformatf("wrap%0d.imem_addr", c), imem_addr2, wrap_addr[c]);
            @(posedge clk);
            #1;
            checkOutput($sformatf("wrap%0d.dec_valid", c), 32'(dec_valid2), (c == 0) ? 32'd0 : 32'd1);
            if (c > 0) begin
                checkOutput($sformatf("wrap%0d.dec_pc", c), dec_pc2, wrap_pc[c-1]);
                checkOutput($sformatf("wrap%0d.dec_instr", c), dec_instr2, memw(wrap_pc[c-1]));
                checkOutput($sformatf("wrap%0d.dec_pc_plus8", c), dec_pc_plus8_2, wrap_pc[c-1] + 32'd8);
            end
        end

        // Randomized traffic against the queue-based reference model.
        for (int i = 0; i < 600; i++) begin
            logic        r, b, rd;
            logic [31:0] t, ea;
            r  = (i == 0) || ($urandom_range(0, 59) == 0);
            b  = ($urandom_range(0, 6) == 0);
            t  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31))) : 32'($urandom);
            rd = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            applyStimulus(r, b, t, rd);
            #1;
            ea = modelAddr(r, b, t, rd);
            checkOutput($sformatf("rnd%0d.imem_addr", i), imem_addr, ea);
            modelStep(r, b, t, rd);
            @(posedge clk);
            #1;
            checkOutput($sformatf("rnd%0d.dec_valid", i), 32'(dec_valid), 32'(m_valid));
            if (m_valid) begin
                checkOutput($sformatf("rnd%0d.dec_pc", i), dec_pc, m_pc);
                checkOutput($sformatf("rnd%0d.dec_instr", i), dec_instr, m_instr);
                checkOutput($sformatf("rnd%0d.dec_pc_plus8", i), dec_pc_plus8, m_pc + 32'd8);
            end
`ifdef FETCH_PERF_EN
            checkOutput($sformatf("rnd%0d.perf_fetched", i), perf_fetched, m_fetched);
            checkOutput($sformatf("rnd%0d.perf_squashed", i), perf_squashed, m_squashed);
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: bus, 32, datapath and address width.
REQ-002 Parameter: reset_pc, 32'h0000_0000, first fetch address after reset.
REQ-003 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: imem_addr  output  bus  byte address to instruction memory; memory samples it at posedge and returns the word one cycle later.
REQ-006 Port: imem_data  input  bus  instruction word for the address sampled at the previous posedge.
REQ-007 Port: branch_valid  input  1  redirect request from execute.
REQ-008 Port: branch_target  input  bus  redirect byte address.
REQ-009 Port: dec_ready  input  1  decode accepts dec_instr this cycle.
REQ-010 Port: dec_valid  output  1  dec_instr/dec_pc hold a valid instruction.
REQ-011 Port: dec_instr  output  bus  fetched instruction word.
REQ-012 Port: dec_pc  output  bus  byte address of dec_instr.
REQ-013 Port: dec_pc_plus8  output  bus  dec_pc+8 (ARMv4 visible PC), combinational from dec_pc.

Function
REQ-014 State: fetch PC (pc_f), in-flight slot (pend_valid, pend_pc), output register (dec_valid, dec_instr, dec_pc).
REQ-015 advance = !dec_valid || dec_ready; transfer to decode occurs when dec_valid && dec_ready.
REQ-016 Normal, advance=1: imem_addr=pc_f; at posedge pend_pc<=pc_f, pend_valid<=1, pc_f<=pc_f+4, output register<={pend_valid, imem_data, pend_pc}.
REQ-017 Stall, advance=0: imem_addr=pend_pc so the memory re-reads the pending word; pc_f, pend and output registers hold.
REQ-018 Branch, branch_valid=1, priority over stall: imem_addr={branch_target[bus-1:2],2'b00}; at posedge dec_valid<=0, pend_pc<=aligned target, pend_valid<=1, pc_f<=aligned target+4.
REQ-019 Branch squashes both the output entry and the in-flight entry in the same cycle; dec_ready is ignored that cycle.
REQ-020 Branch target bits [1:0] are forced to 0.
REQ-021 pc_f+4 and dec_pc+8 wrap modulo 2^bus with no flag.
REQ-022 Latency: first dec_valid=1 is 2 cycles after the reset deassertion edge; first dec_valid after a branch is 2 cycles after the branch edge.
REQ-023 Steady-state throughput with dec_ready held high is one instruction per cycle, with no bubbles.
REQ-024 imem_addr is always word aligned.

Reset
REQ-025 While reset=1, at posedge: pc_f<=reset_pc, pend_valid<=0, dec_valid<=0, dec_instr<=0, dec_pc<=0; reset overrides branch_valid and stall.
REQ-026 While reset=1, imem_addr=reset_pc; imem_data during and one cycle after reset is ignored because pend_valid=0.
REQ-027 Reset asserted mid-stall or mid-branch discards all pending state.

Configuration
REQ-028 Macro FETCH_PERF_EN: when defined, adds outputs perf_fetched[31:0] and perf_squashed[31:0], both reset to 0.
REQ-029 perf_fetched increments by 1 on each transfer.
REQ-030 perf_squashed increments on each branch by the count of valid entries discarded (dec_valid+pend_valid, 0..2).
REQ-031 Both counters wrap modulo 2^32.
REQ-032 Without FETCH_PERF_EN, the perf ports and counters do not exist; all other behaviour is identical.

Structure
REQ-033 Package fetch_pkg SHALL hold: FETCH_BUS=32, INSTR_BYTES=4, DEFAULT_RESET_PC, and typedef fetch_pkt_t {instr, pc}.
REQ-034 The output register and the in-flight slot use fetch_pkt_t.
REQ-035 One sub-module, fetch_pc_gen, SHALL compute next pc_f and imem_addr from advance, branch and reset; everything else stays in fetch_unit.

Verification
REQ-036 Reset release, dec_ready=1, memory holding words I0..I3 at 0x0..0xC -> dec_valid rises on cycle 2; dec_pc sequence 0,4,8,C; dec_instr I0..I3; dec_pc_plus8=8 on the first valid.
REQ-037 dec_ready=0 for 3 cycles while dec_pc=0x4 -> dec_pc=0x4 and dec_instr=I1 held stable; imem_addr=0x8 during the stall; after release the next dec_pc is 0x8 with no skip or duplicate.
REQ-038 branch_valid with target 0x103 during a stall -> next cycle dec_valid=0, imem_addr=0x100 on the branch cycle; 2 cycles later dec_pc=0x100; perf_squashed +=2 when FETCH_PERF_EN is defined.
REQ-039 reset_pc=32'hFFFF_FFF8 -> fetched PCs are FFFF_FFF8, FFFF_FFFC, 0000_0000; dec_pc_plus8 wraps accordingly.
REQ-040 reset=1 asserted together with branch_valid=1 and dec_valid=1 -> next cycle dec_valid=0, imem_addr=reset_pc, perf counters=0.
